mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits on the core's data-memory store/load interface (wr, reade, addr, wr_data, func3, rd_data) as a responder beside the data memory. Core stores to its register window enqueue bytes into a small FIFO. A baud-rate FSM then serialises each byte onto a single tx line as 8N1 frames. Loads return status and configuration in the same cycle, so rd_data is usable by the MEM/WB register without extra latency.

Parameters:
BASE_ADDR, 9'h1F0, byte address of the 16-byte register window; bits [3:0] must be zero.
FIFO_DEPTH, 8, number of TX FIFO entries; power of two, 2..16.
BAUD_DIV_RST, 16'd434, reset value of BAUDDIV, in clocks per bit.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-low reset.
wr  in  1  store strobe from the MEM stage.
reade  in  1  load strobe from the MEM stage.
addr  in  9  byte address from the MEM stage.
wr_data  in  32  store data.
func3  in  3  access size/sign, RISC-V encoding.
rd_data  out  32  load data; combinational.
tx  out  1  serial output; idle high.
irq  out  1  level interrupt: ctrl_en & fifo_empty & state==IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Window select: sel = (addr[8:4] == BASE_ADDR[8:4]) & (addr[1:0] == 0). Offsets 0x0/0x4/0x8/0xC are decoded from addr[3:2].
- Accesses with sel=0 or a misaligned address: no state change, rd_data=0.
- Register map:
  - 0x0 TXDATA (W): enqueues wr_data[7:0] for any store size; reads return 0.
  - 0x4 STATUS (R): [0] busy (state!=IDLE), [1] full, [2] empty, [3] overflow (sticky), [8:4] count; other bits 0. Writes are ignored.
  - 0x8 BAUDDIV (R/W): [15:0]. Updated only by sw (func3=010); sb/sh writes are ignored. A value of 0 is treated as 1.
  - 0xC CTRL (R/W): [0] en. Bit [1] fifo_clr and bit [2] ovf_clr are write-1 pulses, are not stored, and read as 0.
- Load data, selected by func3:
  - 000: sign-extended [7:0].
  - 001: sign-extended [15:0].
  - 010: full word.
  - 100: zero-extended [7:0].
  - 101: zero-extended [15:0].
  - Other func3 values: 0.
- rd_data is 0 whenever reade=0.
- Reset values:
  - tx=1, irq=0, state=IDLE.
  - FIFO empty, count=0, overflow=0.
  - en=0, BAUDDIV=BAUD_DIV_RST, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count.
  - A TXDATA write is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. A write and a pop in the same cycle leave count unchanged.
  - A write while full with no pop drops the data and sets overflow.
  - fifo_clr empties the FIFO. If a clear and a TXDATA write occur in the same cycle, the clear wins and the write is dropped without setting overflow.
  - ovf_clr clears overflow. If it coincides with a new overflow, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If en & !empty: pop the head into the shift register, set baud counter=0, go to START. tx goes low at the same edge.
  - START: tx=0 for BAUDDIV clocks, then go to DATA with bit index=0.
  - DATA: tx=shift[0], LSB first. Each bit lasts BAUDDIV clocks, then the register shifts. After bit 7, go to STOP.
  - STOP: tx=1 for BAUDDIV clocks, then go to IDLE.
- Frame timing: a frame is 10*BAUDDIV clocks, followed by at least 1 IDLE clock before the next START.
- Bit boundary: occurs when the counter >= effective BAUDDIV-1; the counter then resets to 0. A BAUDDIV write mid-frame affects the current bit from the next cycle (live compare).
- en deasserted mid-frame: the current frame completes, and no further pops occur.
- fifo_clr mid-frame: the in-flight byte completes.
- Latency: a store captured at edge E0 makes the FIFO non-empty. The IDLE pop and the tx falling edge occur at edge E1 (one clock later), provided the FSM is idle and en=1.
- wr and reade asserted together: the write takes effect at the clock edge. rd_data reflects pre-edge register values.

Test Plan:
1. Reset check: release reset, then load STATUS -> rd_data=32'h0000_0004 (empty), tx=1, irq=0. Load BAUDDIV -> 434.
2. Single byte: sw BAUDDIV=4; sw CTRL=1; sb TXDATA=8'hA5.
   - tx low 1 clock after the store edge and held for 4 clocks.
   - Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high for 4 clocks.
   - irq=1 after return to IDLE.
3. Overflow: en=0; 9 stores of 0x11..0x19 with FIFO_DEPTH=8.
   - STATUS reads count=8, full=1, overflow=1.
   - After en=1: exactly 0x11..0x18 are transmitted.
   - ovf_clr then clears bit 3.
4. Back-to-back: en=1 with BAUDDIV=2; store 0x00 and 0xFF in consecutive cycles.
   - Two frames of 20 clocks each, separated by exactly 1 idle-high clock.
   - count reads 1 during the first frame.
5. Load formatting: sw BAUDDIV=32'h0000_80F0.
   - lb -> FFFF_FFF0.
   - lbu -> 0000_00F0.
   - lh -> FFFF_80F0.
   - Load at addr BASE+0x9 -> 0.
   - sb to BAUDDIV leaves 0x80F0 unchanged.
6. Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately and FIFO empty. After release, STATUS reads 32'h4.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Loads are combinational so MEM/WB can capture rd_data directly.
module mmio_uart_tx #(
   parameter logic [8:0]  BASE_ADDR    = 9'h1F0,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic        reade,
   input  logic [8:0]  addr,
   input  logic [31:0] wr_data,
   input  logic [2:0]  func3,
   output logic [31:0] rd_data,
   output logic        tx,
   output logic        irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_nx;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]  wptr, rptr;
   logic [4:0]     count;
   logic           ovf, en;
   logic [15:0]    baud, cnt, div_eff;
   logic [7:0]     shift;
   logic [2:0]     bit_idx;
   logic           sel, empty, full, busy, bit_end;
   logic           we_tx, we_baud, we_ctrl;
   logic           fifo_clr, ovf_clr, pop, push, ovf_set;
   logic [1:0]     off;
   logic [31:0]    reg_val;
   logic           unused_bits;

   assign unused_bits = ^wr_data[31:16];

   assign sel = (addr[8:4] == BASE_ADDR[8:4]) & (addr[1:0] == 2'b00);
   assign off = addr[3:2];

   assign we_tx   = wr & sel & (off == 2'd0);
   assign we_baud = wr & sel & (off == 2'd2) & (func3 == 3'b010);
   assign we_ctrl = wr & sel & (off == 2'd3);

   assign fifo_clr = we_ctrl & wr_data[1];
   assign ovf_clr  = we_ctrl & wr_data[2];

   assign empty = (count == 5'd0);
   assign full  = (count == DEPTH);
   assign busy  = (state != IDLE);

   // A pop in the same cycle frees a slot, so a write while full still fits.
   assign pop     = (state == IDLE) & en & ~empty;
   assign push    = we_tx & ~fifo_clr & (~full | pop);
   assign ovf_set = we_tx & ~fifo_clr & full & ~pop;

   assign div_eff = (baud == 16'd0) ? 16'd1 : baud;
   assign bit_end = (cnt >= div_eff - 16'd1);

   assign irq = en & empty & (state == IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         en    <= 1'b0;
         baud  <= BAUD_DIV_RST;
      end else begin
         if (fifo_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + {4'b0, push} - {4'b0, pop};
         end
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         if (we_ctrl) en   <= wr_data[0];
         if (we_baud) baud <= wr_data[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (pop) state_nx = START;
         START: if (bit_end) state_nx = DATA;
         DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
         STOP:  if (bit_end) state_nx = IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      unique case (state)
         IDLE:  tx = 1'b1;
         START: tx = 1'b0;
         DATA:  tx = shift[0];
         STOP:  tx = 1'b1;
      endcase
   end

   // Baud counter, shifter and bit index share one live compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         shift   <= '0;
         bit_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shift <= mem[rptr];
                  cnt   <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
               end else cnt <= cnt + 16'd1;
            end
            DATA: begin
               if (bit_end) begin
                  cnt     <= '0;
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end else cnt <= cnt + 16'd1;
            end
            STOP: begin
               if (bit_end) cnt <= '0;
               else         cnt <= cnt + 16'd1;
            end
         endcase
      end
   end

   always_comb begin
      reg_val = '0;
      unique case (off)
         2'd0: reg_val = '0;
         2'd1: reg_val = {23'b0, count, ovf, empty, full, busy};
         2'd2: reg_val = {16'b0, baud};
         2'd3: reg_val = {31'b0, en};
      endcase
   end

   always_comb begin
      rd_data = '0;
      if (reade && sel) begin
         case (func3)
            3'b000:  rd_data = {{24{reg_val[7]}}, reg_val[7:0]};
            3'b001:  rd_data = {{16{reg_val[15]}}, reg_val[15:0]};
            3'b010:  rd_data = reg_val;
            3'b100:  rd_data = {24'b0, reg_val[7:0]};
            3'b101:  rd_data = {16'b0, reg_val[15:0]};
            default: rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, framing,
// FIFO overflow, back-to-back frames, load formatting, async reset.
module tb_mmio_uart_tx;

   localparam logic [8:0] A_TX   = 9'h1F0;
   localparam logic [8:0] A_STAT = 9'h1F4;
   localparam logic [8:0] A_BAUD = 9'h1F8;
   localparam logic [8:0] A_CTRL = 9'h1FC;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr = 1'b0;
   logic        reade = 1'b0;
   logic [8:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [2:0]  func3 = '0;
   logic [31:0] rd_data;
   logic        tx;
   logic        irq;

   int vectors = 0;
   int miscompares = 0;

   mmio_uart_tx dut (
      .clk(clk), .reset(reset), .wr(wr), .reade(reade),
      .addr(addr), .wr_data(wr_data), .func3(func3),
      .rd_data(rd_data), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [8:0] a, input logic [31:0] d,
                        input logic [2:0] f);
      @(negedge clk);
      wr = 1'b1; addr = a; wr_data = d; func3 = f;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [8:0] a,
                           input logic [2:0] f, input logic [31:0] exp);
      @(negedge clk);
      reade = 1'b1; addr = a; func3 = f;
      #1;
      chk(tag, rd_data, exp);
      reade = 1'b0;
   endtask

   task automatic check_frame(input logic [7:0] b, input int div,
                              input string tag);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int k = 0; k < 10 * div; k++) begin
         if (k > 0) @(negedge clk);
         chk(tag, {31'b0, tx}, {31'b0, fr[k / div]});
      end
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'b0, tx}, 32'h0);
   endtask

   initial begin
      // 1: reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'b0, tx}, 32'h1);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      reset = 1'b1;
      load_chk("t1_status", A_STAT, 3'b010, 32'h4);
      load_chk("t1_baud", A_BAUD, 3'b010, 32'd434);
      chk("t1_tx", {31'b0, tx}, 32'h1);
      chk("t1_irq", {31'b0, irq}, 32'h0);

      // 2: single byte 0xA5 at 4 clocks per bit
      store(A_BAUD, 32'd4, 3'b010);
      store(A_CTRL, 32'h1, 3'b010);
      chk("t2_irq_en", {31'b0, irq}, 32'h1);
      store(A_TX, 32'hA5, 3'b000);
      chk("t2_tx_e0", {31'b0, tx}, 32'h1);
      chk("t2_irq_busy", {31'b0, irq}, 32'h0);
      @(negedge clk);
      check_frame(8'hA5, 4, "t2_frame");
      @(negedge clk);
      chk("t2_idle_tx", {31'b0, tx}, 32'h1);
      chk("t2_idle_irq", {31'b0, irq}, 32'h1);

      // 3: overflow with en=0, then drain
      store(A_CTRL, 32'h0, 3'b010);
      for (int i = 0; i < 9; i++)
         store(A_TX, 32'h11 + i, 3'b000);
      load_chk("t3_status_full", A_STAT, 3'b010, 32'h8A);
      store(A_CTRL, 32'h1, 3'b010);
      for (int i = 0; i < 8; i++) begin
         wait_start("t3_start");
         check_frame(8'(8'h11 + i), 4, "t3_frame");
      end
      repeat (60) @(negedge clk);
      chk("t3_no_ninth", {31'b0, tx}, 32'h1);
      load_chk("t3_status_drained", A_STAT, 3'b010, 32'hC);
      chk("t3_irq", {31'b0, irq}, 32'h1);
      store(A_CTRL, 32'h5, 3'b010);
      load_chk("t3_ovf_clr", A_STAT, 3'b010, 32'h4);

      // 4: back-to-back frames at 2 clocks per bit
      store(A_BAUD, 32'd2, 3'b010);
      @(negedge clk);
      wr = 1'b1; addr = A_TX; wr_data = 32'h00; func3 = 3'b000;
      @(negedge clk);
      wr_data = 32'hFF;
      @(negedge clk);
      wr = 1'b0;
      reade = 1'b1; addr = A_STAT; func3 = 3'b010;
      #1;
      chk("t4_count1", rd_data, 32'h11);
      reade = 1'b0;
      check_frame(8'h00, 2, "t4_frame0");
      @(negedge clk);
      chk("t4_gap_tx", {31'b0, tx}, 32'h1);
      reade = 1'b1; addr = A_STAT; func3 = 3'b010;
      #1;
      chk("t4_gap_status", rd_data, 32'h10);
      reade = 1'b0;
      @(negedge clk);
      check_frame(8'hFF, 2, "t4_frame1");
      @(negedge clk);
      chk("t4_end_irq", {31'b0, irq}, 32'h1);

      // 5: load formatting
      store(A_BAUD, 32'h0000_80F0, 3'b010);
      load_chk("t5_lb", A_BAUD, 3'b000, 32'hFFFF_FFF0);
      load_chk("t5_lbu", A_BAUD, 3'b100, 32'h0000_00F0);
      load_chk("t5_lh", A_BAUD, 3'b001, 32'hFFFF_80F0);
      load_chk("t5_lhu", A_BAUD, 3'b101, 32'h0000_80F0);
      load_chk("t5_misalign", 9'h1F9, 3'b010, 32'h0);
      load_chk("t5_bad_f3", A_BAUD, 3'b011, 32'h0);
      load_chk("t5_txdata", A_TX, 3'b010, 32'h0);
      load_chk("t5_ctrl", A_CTRL, 3'b010, 32'h1);
      load_chk("t5_outside", 9'h0F8, 3'b010, 32'h0);
      store(A_BAUD, 32'h12, 3'b000);
      load_chk("t5_sb_ignored", A_BAUD, 3'b010, 32'h80F0);
      @(negedge clk);
      reade = 1'b0; addr = A_BAUD; func3 = 3'b010;
      #1;
      chk("t5_no_reade", rd_data, 32'h0);

      // 6: reset during DATA bit 3 of 0xA5
      store(A_BAUD, 32'd4, 3'b010);
      store(A_TX, 32'hA5, 3'b000);
      store(A_TX, 32'h3C, 3'b000);
      repeat (16) @(negedge clk);
      chk("t6_mid_bit3", {31'b0, tx}, 32'h0);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_tx", {31'b0, tx}, 32'h1);
      reade = 1'b1; addr = A_STAT; func3 = 3'b010;
      #1;
      chk("t6_in_reset", rd_data, 32'h4);
      reade = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      load_chk("t6_status", A_STAT, 3'b010, 32'h4);
      load_chk("t6_baud", A_BAUD, 3'b010, 32'd434);
      chk("t6_tx", {31'b0, tx}, 32'h1);
      chk("t6_irq", {31'b0, irq}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
